// File: rtl/morse_decoder.sv
// Morse receiver: measures mark/space lengths on a synchronised input and
// decodes letters Q..X into the encoder's 3-bit letter code.
module morse_decoder #(
  parameter int unsigned TICKS_PER_UNIT = 25000000,
  parameter int unsigned DASH_MIN       = 2 * TICKS_PER_UNIT,
  parameter int unsigned GAP_MIN        = 2 * TICKS_PER_UNIT,
  parameter int unsigned GLITCH_MAX     = TICKS_PER_UNIT / 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy,
  output logic [2:0] sym_count,
  output logic [3:0] symbols
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_MIN - 1);
  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sym_count_q, sym_count_d;
  logic [3:0]       symbols_q, symbols_d;
  logic             overflow_q, overflow_d;
  logic [2:0]       letter_q, letter_d;
  logic             letter_valid_q, letter_valid_d;
  logic             letter_error_q, letter_error_d;

  logic             s_in;
  logic [CNT_W-1:0] cnt_inc;
  logic             match;
  logic [2:0]       match_code;

  assign s_in    = sync_q[1];
  assign sync_d  = {sync_q[0], morse_in};
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // Symbol count and right-aligned pattern together select the letter.
  always_comb begin
    match      = 1'b1;
    match_code = 3'd0;
    case ({sym_count_q, symbols_q})
      7'b100_1101: match_code = 3'd0;
      7'b011_0010: match_code = 3'd1;
      7'b011_0000: match_code = 3'd2;
      7'b001_0001: match_code = 3'd3;
      7'b011_0001: match_code = 3'd4;
      7'b100_0001: match_code = 3'd5;
      7'b011_0011: match_code = 3'd6;
      7'b100_1001: match_code = 3'd7;
      default:     match      = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sym_count_d    = sym_count_q;
    symbols_d      = symbols_q;
    overflow_d     = overflow_q;
    letter_d       = letter_q;
    letter_valid_d = 1'b0;
    letter_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_in) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end
      end

      MARK: begin
        if (s_in) begin
          cnt_d = cnt_inc;
        end else if (cnt_q < GLITCH_C) begin
          state_d = (sym_count_q != 3'd0) ? SPACE : IDLE;
          cnt_d   = CNT_ONE;
        end else begin
          if (sym_count_q == 3'd4) begin
            overflow_d = 1'b1;
          end else begin
            symbols_d   = {symbols_q[2:0], (cnt_q >= DASH_C)};
            sym_count_d = sym_count_q + 3'd1;
          end
          state_d = SPACE;
          cnt_d   = CNT_ONE;
        end
      end

      SPACE: begin
        if (s_in) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == GAP_LAST) begin
          state_d = EMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      EMIT: begin
        if (match && !overflow_q) begin
          letter_d       = match_code;
          letter_valid_d = 1'b1;
        end else begin
          letter_error_d = 1'b1;
        end
        sym_count_d = 3'd0;
        symbols_d   = 4'd0;
        overflow_d  = 1'b0;
        // A mark starting right at the end of the gap begins the next letter.
        if (s_in) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q        <= IDLE;
      sync_q         <= 2'b00;
      cnt_q          <= '0;
      sym_count_q    <= 3'd0;
      symbols_q      <= 4'd0;
      overflow_q     <= 1'b0;
      letter_q       <= 3'd0;
      letter_valid_q <= 1'b0;
      letter_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      sym_count_q    <= sym_count_d;
      symbols_q      <= symbols_d;
      overflow_q     <= overflow_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      letter_error_q <= letter_error_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = letter_valid_q;
  assign letter_error = letter_error_q;
  assign busy         = (state_q != IDLE);
  assign sym_count    = sym_count_q;
  assign symbols      = symbols_q;

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receives a single-bit Morse signal (a key line or the LEDR output of the Morse encoder) and decodes letters Q..X back to the 3-bit letter code used by the encoder.
- Measures mark (high) and space (low) durations in CLOCK_50 cycles against a configurable unit time.
- Classifies each mark as dot or dash and detects the end-of-letter gap.
- Emits a one-cycle valid or error pulse per letter. Sits on the receive side of the board, feeding LEDs/HEX display or a loopback checker.

Parameters:
- TICKS_PER_UNIT, 25000000: CLOCK_50 cycles per Morse unit (0.5 s); set to 8 in simulation.
- DASH_MIN, 2*TICKS_PER_UNIT: mark length (cycles) at or above which a mark is a dash.
- GAP_MIN, 2*TICKS_PER_UNIT: consecutive low cycles that terminate a letter.
- GLITCH_MAX, TICKS_PER_UNIT/4: marks shorter than this are discarded as noise.
- CNT_W, 32: duration counter width.

Ports:
- CLOCK_50, input, 1: 50 MHz clock; all logic on its rising edge.
- RESET, input, 1: synchronous, active-high reset.
- morse_in, input, 1: raw Morse signal, 1 = tone/LED on; asynchronous to CLOCK_50.
- letter, output, 3: decoded letter code. Q=000, R=001, S=010, T=011, U=100, V=101, W=110, X=111.
- letter_valid, output, 1: one-cycle pulse; letter updated that cycle.
- letter_error, output, 1: one-cycle pulse; unrecognised or over-length letter.
- busy, output, 1: high in MARK, SPACE and EMIT.
- sym_count, output, 3: symbols captured in the current letter (debug).
- symbols, output, 4: captured pattern, right-aligned, 1 = dash (debug).

Behaviour:
- Input conditioning:
  - morse_in passes through a 2-flop synchronizer to produce s_in.
  - All timing refers to s_in, which adds 2 cycles of latency.
- Reset:
  - RESET=1 forces state IDLE and clears letter, letter_valid, letter_error, sym_count, symbols and the duration counter.
  - RESET has priority over every other event, including an EMIT in the same cycle.
  - A letter in progress is discarded with no pulse.
- Counter:
  - cnt counts consecutive cycles of the current level.
  - It loads 1 on every state entry that follows a level change, increments by 1 per cycle, and saturates at all-ones (no wrap).
- FSM states: IDLE, MARK, SPACE, EMIT.
- IDLE:
  - s_in=1 -> MARK, cnt=1.
  - Otherwise stay.
- MARK, while s_in=1: cnt++.
- MARK, on s_in=0:
  - If cnt < GLITCH_MAX: discard the mark. Go to SPACE with cnt=1 if sym_count>0, else to IDLE.
  - Else if sym_count==4: set the internal overflow flag; symbols are unchanged.
  - Else: symbols <= {symbols[2:0], (cnt>=DASH_MIN)}; sym_count++.
  - In both non-glitch cases, go to SPACE with cnt=1.
- SPACE:
  - s_in=1 -> MARK, cnt=1.
  - s_in=0 and cnt==GAP_MIN-1 -> EMIT.
  - Otherwise cnt++.
- EMIT (exactly one cycle, then IDLE):
  - Match (sym_count, symbols) against the table below.
  - On a match with no overflow: letter <= code and letter_valid=1.
  - Otherwise: letter_error=1 and letter keeps its previous value.
  - In both cases clear sym_count, symbols and overflow.
  - s_in=1 during EMIT is not lost: next state is MARK with cnt=1 instead of IDLE.
- Decode table (len, pattern right-aligned):
  - Q: 4, 1101
  - R: 3, 010
  - S: 3, 000
  - T: 1, 1
  - U: 3, 001
  - V: 4, 0001
  - W: 3, 011
  - X: 4, 1001
  - All other (len, pattern) combinations raise letter_error.
- Latency: letter_valid/letter_error asserts in the cycle after s_in has been sampled low for GAP_MIN consecutive cycles following the last accepted mark.
- Pulses: letter_valid and letter_error are registered, never both high, and never high for more than one cycle.
- A lone glitch from IDLE produces no pulse and no state change beyond MARK->IDLE.
- A mark held indefinitely saturates cnt and classifies as a dash on release.
- busy = (state != IDLE).

Test Plan (TICKS_PER_UNIT=8: DASH_MIN=16, GAP_MIN=16, GLITCH_MAX=2):
1. morse_in high 24 cycles then low 30 -> one letter_valid with letter=011 (T), letter_error never high, busy returns to 0.
2. Q sent as marks 24,24,8,24 with 8-cycle gaps, then low 30 -> letter=000, single valid pulse. Repeat the bench loop for all eight encoder letters, each matching its code.
3. S (three 8-cycle dots, 8-cycle gaps) with a 1-cycle high glitch inserted mid-gap -> letter=010 valid; sym_count peaks at 3.
4. Five 8-cycle dots, then low 30 -> letter_error pulse only, letter unchanged from its previous value.
5. Dot-dash (A, not in table), then low 30 -> letter_error; then R (8,24,8) -> letter=001 valid.
6. RESET asserted for 1 cycle after two dots of R, then full R sent -> no pulse for the aborted letter; later letter=001 valid. RESET in the same cycle as EMIT -> no pulse, all outputs 0.
